mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 91 +++++++++
 tb/tb_mem_responder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-addressed memory responder with host preload port and fixed-latency reads.
// Latency: reads return exactly RD_LAT cycles after acceptance; writes commit at end of cycle.
// Backpressure: none; every qualified request is accepted, and the read pipe always advances.
module mem_responder #(
    parameter int MEM_AW    = 16,
    parameter int MEM_DW    = 32,
    parameter int ADDR_BITS = 10,
    parameter int RD_LAT    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sm_ena,
    input  logic                 mem_req,
    input  logic                 mem_write,
    input  logic [MEM_AW-1:0]    mem_addr,
    input  logic [MEM_DW-1:0]    mem_wdata,
    output logic                 mem_rdata_vld,
    output logic [MEM_DW-1:0]    mem_rdata,
    input  logic                 ld_we,
    input  logic [ADDR_BITS-1:0] ld_addr,
    input  logic [MEM_DW-1:0]    ld_wdata,
    output logic                 idle,
    output logic                 err
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [MEM_DW-1:0]    storage [DEPTH];
    logic                 acc;
    logic                 rd_acc;
    logic                 wr_acc;
    logic                 in_range;
    logic [ADDR_BITS-1:0] idx;

    logic [RD_LAT-1:0]    vld_pipe;
    logic [RD_LAT-1:0]    hit_pipe;
    logic [MEM_DW-1:0]    dat_pipe [RD_LAT];
    logic                 err_q;

    // Requests count only when qualified and outside reset.
    assign acc      = mem_req & sm_ena & ~rst;
    assign rd_acc   = acc & ~mem_write;
    assign wr_acc   = acc & mem_write;
    // Any address bit above the storage index marks the access as out of range.
    assign in_range = (mem_addr >> ADDR_BITS) == '0;
    assign idx      = mem_addr[ADDR_BITS-1:0];

    // Storage is never cleared; the mem write is placed last so it wins a same-address collision with ld.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (ld_we)
                storage[ld_addr] <= ld_wdata;
            if (wr_acc && in_range)
                storage[idx] <= mem_wdata;
        end
    end

    // Read shift pipe: stage 0 captures the array, later stages just delay it.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            hit_pipe <= '0;
            for (int i = 0; i < RD_LAT; i++)
                dat_pipe[i] <= '0;
        end else begin
            vld_pipe[0] <= rd_acc;
            hit_pipe[0] <= rd_acc & in_range;
            dat_pipe[0] <= (rd_acc && in_range) ? storage[idx] : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                hit_pipe[i] <= hit_pipe[i-1];
                dat_pipe[i] <= dat_pipe[i-1];
            end
        end
    end

    // Sticky flag for any accepted out-of-range access.
    always_ff @(posedge clk) begin
        if (rst)
            err_q <= 1'b0;
        else if (acc && !in_range)
            err_q <= 1'b1;
    end

    // Outputs are forced quiet during reset so the reset cycle itself is clean.
    assign mem_rdata_vld = vld_pipe[RD_LAT-1] & ~rst;
    assign mem_rdata     = (mem_rdata_vld && hit_pipe[RD_LAT-1]) ? dat_pipe[RD_LAT-1] : '0;
    assign err           = err_q & ~rst;
    assign idle          = rst | (~(|vld_pipe) & ~rd_acc);

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int MEM_AW    = 16;
    localparam int MEM_DW    = 32;
    localparam int ADDR_BITS = 10;
    localparam int RD_LAT    = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 sm_ena;
    logic                 mem_req;
    logic                 mem_write;
    logic [MEM_AW-1:0]    mem_addr;
    logic [MEM_DW-1:0]    mem_wdata;
    logic                 mem_rdata_vld;
    logic [MEM_DW-1:0]    mem_rdata;
    logic                 ld_we;
    logic [ADDR_BITS-1:0] ld_addr;
    logic [MEM_DW-1:0]    ld_wdata;
    logic                 idle;
    logic                 err;

    mem_responder #(
        .MEM_AW(MEM_AW), .MEM_DW(MEM_DW), .ADDR_BITS(ADDR_BITS), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst), .sm_ena(sm_ena), .mem_req(mem_req),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata_vld(mem_rdata_vld), .mem_rdata(mem_rdata),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .idle(idle), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          cyc;
        logic [31:0] dat;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] dat;   // write data, or expected read data
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // Scoreboard: every valid beat must match the oldest outstanding read, at its exact cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (sbq.size() != 0 && sbq[0].cyc < cyc) begin
                tests++;
                fails++;
                $display("FAIL missing_vld cyc=%0d got=no_vld want=vld_at_%0d", cyc, sbq[0].cyc);
                void'(sbq.pop_front());
            end
            if (mem_rdata_vld) begin
                tests++;
                if (sbq.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_vld cyc=%0d got=%h want=no_vld", cyc, mem_rdata);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    if (e.cyc != cyc || mem_rdata !== e.dat) begin
                        fails++;
                        $display("FAIL rd_data cyc=%0d got=%h want=%h@%0d", cyc, mem_rdata, e.dat, e.cyc);
                    end
                end
            end else begin
                chk("rdata_zero_idle", mem_rdata, 32'h0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rst = 1'b0; sm_ena = 1'b0; mem_req = 1'b0; mem_write = 1'b0;
        mem_addr = '0; mem_wdata = '0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [31:0] e);
        exp_t x;
        tick();
        sm_ena = 1'b1; mem_req = 1'b1; mem_addr = a;
        x.cyc = cyc + RD_LAT;
        x.dat = e;
        sbq.push_back(x);
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        tick();
        sm_ena = 1'b1; mem_req = 1'b1; mem_write = 1'b1; mem_addr = a; mem_wdata = d;
    endtask

    task automatic ld(input logic [ADDR_BITS-1:0] a, input logic [31:0] d);
        tick();
        ld_we = 1'b1; ld_addr = a; ld_wdata = d;
    endtask

    task automatic drain();
        repeat (RD_LAT + 2) tick();
    endtask

    task automatic chk_reset_outputs();
        @(negedge clk);
        chk("rst_vld", {31'b0, mem_rdata_vld}, 32'h0);
        chk("rst_rdata", mem_rdata, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        chk("rst_idle", {31'b0, idle}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 16'h0003, 32'h0000A5A5};
        tbl[1]  = '{1'b0, 16'h0003, 32'h0000A5A5};
        tbl[2]  = '{1'b0, 16'h0005, 32'h00001234};
        tbl[3]  = '{1'b1, 16'h0009, 32'hDEADBEEF};
        tbl[4]  = '{1'b0, 16'h0009, 32'hDEADBEEF};
        tbl[5]  = '{1'b1, 16'h03FF, 32'hCAFEF00D};
        tbl[6]  = '{1'b0, 16'h03FF, 32'hCAFEF00D};
        tbl[7]  = '{1'b0, 16'h0002, 32'd12};
        tbl[8]  = '{1'b0, 16'h0001, 32'd11};
        tbl[9]  = '{1'b1, 16'h0002, 32'h00000000};
        tbl[10] = '{1'b0, 16'h0002, 32'h00000000};

        rst = 1'b1; sm_ena = 1'b0; mem_req = 1'b0; mem_write = 1'b0;
        mem_addr = '0; mem_wdata = '0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
        repeat (2) @(posedge clk);
        chk_reset_outputs();

        // Host preload
        ld(10'd5, 32'h1234);
        for (int i = 0; i < 4; i++) ld(10'(i), 32'(10 + i));

        // Back-to-back reads keep idle low until the last beat has left
        for (int i = 0; i < 4; i++) begin
            rd(16'(i), 32'(10 + i));
            @(negedge clk);
            chk("idle_issue", {31'b0, idle}, 32'h0);
        end
        for (int k = 0; k < RD_LAT; k++) begin
            tick();
            @(negedge clk);
            chk("idle_inflight", {31'b0, idle}, 32'h0);
        end
        tick();
        @(negedge clk);
        chk("idle_after", {31'b0, idle}, 32'h1);

        // Vector table
        for (int i = 0; i < 11; i++) begin
            if (tbl[i].wr) wr(tbl[i].addr, tbl[i].dat);
            else           rd(tbl[i].addr, tbl[i].dat);
        end
        drain();
        @(negedge clk);
        chk("err_clean", {31'b0, err}, 32'h0);

        // Unqualified requests do nothing, even out of range
        for (int k = 0; k < 3; k++) begin
            tick();
            mem_req = 1'b1; sm_ena = 1'b0;
            mem_write = (k == 0);
            mem_addr = (k == 2) ? 16'hFFFF : 16'h0005;
            mem_wdata = 32'h00000BAD;
        end
        rd(16'h0005, 32'h1234);
        // Collision: mem write beats ld write
        tick();
        sm_ena = 1'b1; mem_req = 1'b1; mem_write = 1'b1; mem_addr = 16'h0007; mem_wdata = 32'h2222;
        ld_we = 1'b1; ld_addr = 10'd7; ld_wdata = 32'h1111;
        rd(16'h0007, 32'h2222);
        // ld works with sm_ena low
        ld(10'd8, 32'h88);
        rd(16'h0008, 32'h88);
        drain();
        @(negedge clk);
        chk("err_no_sm_ena", {31'b0, err}, 32'h0);

        // Out-of-range: write dropped (no aliasing), read returns 0, err sticks
        wr(16'h0403, 32'h5555);
        rd(16'h0003, 32'h0000A5A5);
        rd(16'hFFFF, 32'h0);
        drain();
        @(negedge clk);
        chk("err_set", {31'b0, err}, 32'h1);
        repeat (5) tick();
        @(negedge clk);
        chk("err_sticky", {31'b0, err}, 32'h1);

        // Reset drops the in-flight read; storage and ignored writes checked after
        tick();
        sm_ena = 1'b1; mem_req = 1'b1; mem_addr = 16'h0009;
        for (int k = 0; k < 2; k++) begin
            tick();
            rst = 1'b1;
            ld_we = 1'b1; ld_addr = 10'd9; ld_wdata = 32'h9999;
            sm_ena = 1'b1; mem_req = 1'b1; mem_write = 1'b1; mem_addr = 16'h0009; mem_wdata = 32'h7777;
            chk_reset_outputs();
        end
        repeat (RD_LAT + 2) tick();
        @(negedge clk);
        chk("err_after_rst", {31'b0, err}, 32'h0);
        rd(16'h0009, 32'hDEADBEEF);
        rd(16'h0007, 32'h2222);
        drain();

        chk("sb_empty", 32'(sbq.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
